// File: rtl/avg_accum.sv
// avg_accum: streaming block averager; sums 2^LOG2_N samples taken over a
// valid/ready handshake and presents sum and (sum >> sa), optionally rounded.
// Ports: clk, rst (sync, active-high)
//        in_data/in_valid/in_ready : sample stream
//        sa, rnd : shift amount and round enable, latched with the first sample
//        clr : abort a partial block
//        avg/sum/out_valid/out_ready : registered result with backpressure
module avg_accum #(
    parameter int DATAWIDTH = 16,
    parameter int LOG2_N    = 3,
    localparam int ACCW     = DATAWIDTH + LOG2_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           sa,
    input  logic                 rnd,
    input  logic                 clr,
    output logic [DATAWIDTH-1:0] avg,
    output logic [ACCW-1:0]      sum,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = ACCW + 1;
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ACCW-1:0]       acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            sa_q, sa_d;
    logic                  rnd_q, rnd_d;
    logic [DATAWIDTH-1:0]  avg_q, avg_d;
    logic [ACCW-1:0]       sum_q, sum_d;
    logic                  in_ready_q;

    logic                  accept;
    logic [ACCW-1:0]       acc_nx;
    logic [PW-1:0]         half;
    logic [PW-1:0]         p;
    logic [PW-1:0]         r;

    assign accept    = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign avg       = avg_q;
    assign sum       = sum_q;

    // Result datapath works on the sum including the sample being accepted,
    // so the registered result is ready the cycle after the N-th accept.
    always_comb begin
        acc_nx = acc_q + ACCW'(in_data);
        half   = '0;
        if (rnd_q && (sa_q != 8'd0) && (32'(sa_q) <= ACCW)) begin
            half = PW'(1) << (sa_q - 8'd1);
        end
        p = {1'b0, acc_nx} + half;
        if (32'(sa_q) > ACCW) begin
            r = '0;
        end else begin
            r = p >> sa_q;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        rnd_d   = rnd_q;
        avg_d   = avg_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    acc_d   = ACCW'(in_data);
                    cnt_d   = CW'(1);
                    sa_d    = sa;
                    rnd_d   = rnd;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (clr) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    acc_d = acc_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        avg_d   = r[DATAWIDTH-1:0];
                        sum_d   = acc_nx;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // clr is deliberately ignored here: a finished result is kept
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            sa_q       <= '0;
            rnd_q      <= 1'b0;
            avg_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sa_q       <= sa_d;
            rnd_q      <= rnd_d;
            avg_q      <= avg_d;
            sum_q      <= sum_d;
            in_ready_q <= (state_d != DONE);
        end
    end

endmodule

// File: tb/tb_avg_accum.sv
// tb_avg_accum: directed and randomized checks of avg_accum against an
// arithmetic reference model of block sum, rounding and shifting.
module tb_avg_accum;

    localparam int DW   = 16;
    localparam int L2N  = 3;
    localparam int N    = 1 << L2N;
    localparam int ACCW = DW + L2N;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      sa = '0;
    logic            rnd = 1'b0;
    logic            clr = 1'b0;
    logic [DW-1:0]   avg;
    logic [ACCW-1:0] sum;
    logic            out_valid;
    logic            out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    int unsigned smp[$];
    int          blk_sa;
    bit          blk_rnd;

    avg_accum #(.DATAWIDTH(DW), .LOG2_N(L2N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sa        (sa),
        .rnd       (rnd),
        .clr       (clr),
        .avg       (avg),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint model_sum();
        longint s = 0;
        foreach (smp[i]) s += longint'(smp[i]);
        return s;
    endfunction

    function automatic longint model_avg(input longint s, input int sh,
                                         input bit rd);
        longint pre = s;
        if (sh > ACCW) return 0;
        if (rd && sh >= 1) pre = pre + (longint'(1) << (sh - 1));
        return (pre >> sh) & ((longint'(1) << DW) - 1);
    endfunction

    // Offer every queued sample; gap_pct inserts idle cycles, scramble
    // changes sa/rnd after the first accept (must have no effect).
    task automatic feed(input int gap_pct, input bit scramble);
        int budget = 2000;
        sa  = 8'(blk_sa);
        rnd = blk_rnd;
        foreach (smp[i]) begin
            bit done = 0;
            while (!done) begin
                if (budget == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL feed_timeout: observed stuck expected accept");
                    in_valid = 1'b0;
                    return;
                end
                budget--;
                if (int'($urandom_range(99)) < gap_pct) begin
                    in_valid = 1'b0;
                    tick();
                end else begin
                    bit rdy = in_ready;
                    in_valid = 1'b1;
                    in_data  = DW'(smp[i]);
                    tick();
                    done = rdy;
                end
            end
            if (scramble && i == 0) begin
                sa  = 8'($urandom);
                rnd = 1'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic deliver(input int hold);
        longint es = model_sum();
        longint ea = model_avg(es, blk_sa, blk_rnd);
        check("ov_after_last", 64'(out_valid), 64'd1);
        check("sum", 64'(sum), 64'(es));
        check("avg", 64'(avg), 64'(ea));
        check("in_ready_done", 64'(in_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            tick();
            check("ov_hold", 64'(out_valid), 64'd1);
            check("in_ready_hold", 64'(in_ready), 64'd0);
            check("sum_hold", 64'(sum), 64'(es));
            check("avg_hold", 64'(avg), 64'(ea));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ov_drop", 64'(out_valid), 64'd0);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        check("sum_after", 64'(sum), 64'(es));
    endtask

    task automatic fill_const(input int unsigned v, input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(v);
    endtask

    task automatic fill_rand(input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back($urandom_range(65535));
    endtask

    initial begin
        // reset
        tick();
        tick();
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_avg", 64'(avg), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // truncate 1..8
        smp.delete();
        for (int i = 1; i <= N; i++) smp.push_back(i);
        blk_sa = 3; blk_rnd = 0;
        feed(0, 0);
        check("trunc_sum", 64'(sum), 64'd36);
        check("trunc_avg", 64'(avg), 64'd4);
        deliver(0);

        // round 1..8
        blk_rnd = 1;
        feed(0, 0);
        check("round_avg", 64'(avg), 64'd5);
        deliver(0);

        // 1x7 then 2, rounded
        fill_const(1, N - 1);
        smp.push_back(2);
        feed(0, 0);
        check("round9_sum", 64'(sum), 64'd9);
        check("round9_avg", 64'(avg), 64'd1);
        deliver(0);

        // full scale with three shifts
        fill_const(16'hFFFF, N);
        blk_sa = 3; blk_rnd = 0;
        feed(0, 0);
        check("fs_sum", 64'(sum), 64'h7FFF8);
        check("fs_avg_sa3", 64'(avg), 64'hFFFF);
        deliver(0);
        blk_sa = 0;
        feed(0, 0);
        check("fs_avg_sa0", 64'(avg), 64'hFFF8);
        deliver(0);
        blk_sa = 40; blk_rnd = 1;
        feed(0, 0);
        check("fs_avg_sa40", 64'(avg), 64'd0);
        deliver(0);

        // gaps, backpressure, sa scrambled mid-block
        fill_rand(N);
        blk_sa = 2; blk_rnd = 1;
        feed(30, 1);
        deliver(5);

        // abort after 5 samples, offered sample during clr is dropped
        fill_rand(5);
        blk_sa = 3; blk_rnd = 0;
        feed(0, 0);
        check("partial_no_ov", 64'(out_valid), 64'd0);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hAAAA;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        fill_const(16'h0010, N);
        feed(0, 0);
        check("abort_sum", 64'(sum), 64'h80);
        check("abort_avg", 64'(avg), 64'h10);
        deliver(0);

        // clr in DONE is ignored
        fill_rand(N);
        blk_sa = 1; blk_rnd = 1;
        feed(10, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        deliver(1);

        // reset mid-block
        fill_rand(4);
        feed(0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_ov", 64'(out_valid), 64'd0);
        tick();
        check("rstmid_in_ready", 64'(in_ready), 64'd1);

        // reset with result pending
        fill_rand(N);
        blk_sa = 3; blk_rnd = 0;
        feed(0, 0);
        check("pend_ov", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstdone_ov", 64'(out_valid), 64'd0);
        check("rstdone_avg", 64'(avg), 64'd0);
        check("rstdone_sum", 64'(sum), 64'd0);
        tick();
        check("rstdone_in_ready", 64'(in_ready), 64'd1);
        fill_rand(N);
        feed(0, 0);
        deliver(0);

        // randomized blocks
        for (int b = 0; b < 8; b++) begin
            fill_rand(N);
            blk_sa  = $urandom_range(24);
            blk_rnd = 1'($urandom);
            feed(25, 1);
            deliver($urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avg_accum.md
# avg_accum

Parametrised streaming averager. It accepts one DATAWIDTH-bit sample per cycle over a valid/ready handshake and accumulates a block of 2^LOG2_N samples. It then presents the block sum shifted right by a runtime shift amount, optionally rounded, on a registered output with backpressure. It replaces fixed 8-input combinational adder-tree averagers where inputs arrive serially and block size, width and rounding must be configurable.

## Interface

Parameters:
- DATAWIDTH, 16, sample and average width (≥ 2).
- LOG2_N, 3, log2 of samples per block (1..8); N = 2^LOG2_N.
- ACCW = DATAWIDTH + LOG2_N is derived, not overridable: the accumulator and sum width.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATAWIDTH  unsigned sample.
- in_valid  input  1  sample present.
- in_ready  output  1  block can take a sample this cycle.
- sa  input  8  right-shift amount; sampled with the first sample of each block.
- rnd  input  1  1 = round half-up, 0 = truncate; sampled with the first sample of each block.
- clr  input  1  synchronous abort of a partial block.
- avg  output  DATAWIDTH  registered result, low DATAWIDTH bits of the shifted sum.
- sum  output  ACCW  registered raw block sum.
- out_valid  output  1  avg/sum valid.
- out_ready  input  1  consumer accepts the result.

## Operation

- A sample is accepted when in_valid && in_ready.
- States:
  - IDLE: cnt = 0; in_ready = 1. An accepted sample sets acc = in_data, latches sa and rnd, sets cnt = 1 and moves to ACCUM. If N = 1 is impossible (LOG2_N ≥ 1), this state always moves to ACCUM.
  - ACCUM: in_ready = 1. Each accepted sample does acc += in_data and cnt += 1. On the N-th sample the block moves to DONE.
  - DONE: in_ready = 0 and out_valid = 1. Once out_valid && out_ready, the block returns to IDLE.
- Arithmetic is unsigned.
  - acc is ACCW bits wide and cannot overflow.
  - When rnd_l = 1 and 1 ≤ sa_l ≤ ACCW, the pre-shift value is p = acc + 2^(sa_l−1), computed at ACCW+1 bits. Otherwise p = acc.
  - r = p >> sa_l. Any sa_l ≥ ACCW+1 gives r = 0.
  - avg = r[DATAWIDTH−1:0], truncated with no saturation. sum = acc.
- avg and sum are loaded on the transition into DONE. They hold until the handshake completes and after it; only out_valid qualifies them.
- clr in IDLE or ACCUM: on the next edge acc = 0, cnt = 0, state = IDLE, and any sample offered in that cycle is discarded. clr in DONE is ignored; a completed result is never dropped.
- rst has priority over everything.
  - Outputs after rst: state = IDLE, acc = 0, cnt = 0, avg = 0, sum = 0, out_valid = 0.
  - in_ready = 1 from the first edge after rst deasserts. It is 0 while rst is high.
- sa and rnd changes mid-block have no effect until the next block's first sample.

## Timing

- Throughput is one sample per cycle inside a block.
- Latency: if the N-th sample is accepted at edge t, out_valid = 1 after edge t, so the result is visible in cycle t+1.
- Minimum block period is N+1 cycles: N samples plus one DONE cycle with out_ready = 1. There is no overlap between blocks.
- Handshake rules:
  - in_ready depends only on state (registered). It has no combinational path from in_valid or out_ready.
  - out_valid, once high, stays high and avg/sum stay stable until out_ready is seen high at an edge.
  - Gaps in in_valid stall accumulation without loss. cnt and acc hold.
- rst asserted mid-block or in DONE takes effect at the next edge: the partial or pending result is lost and out_valid drops.

## Test plan

- Truncate: DATAWIDTH=16, LOG2_N=3, sa=3, rnd=0, samples 1..8 back-to-back -> sum=36, avg=4, out_valid exactly 1 cycle after the 8th accept.
- Round: same samples with rnd=1 -> avg=5 ((36+4)>>3). Samples 1,1,1,1,1,1,1,2 with sa=3, rnd=1 -> sum=9, avg=1.
- Full scale: 8 × 0xFFFF, sa=3 -> sum=0x7FFF8, avg=0xFFFF. Same samples with sa=0 -> avg=0xFFF8 (truncated). Same samples with sa=40 -> avg=0.
- Backpressure and gaps:
  - Insert random in_valid gaps and hold out_ready=0 for 5 cycles -> in_ready=0 and avg/sum stable throughout DONE.
  - The next block starts only after the handshake; sa changed mid-block is ignored until then.
- Abort: clr after 5 samples, then 8 samples of 0x0010 with sa=3 -> sum=0x80, avg=0x10. clr pulsed in DONE -> result still delivered.
- Reset: rst after 4 samples, then with out_valid high -> next cycle out_valid=0, avg=0, sum=0, in_ready=1. A following full block averages correctly.
